signed_divider: RTL and testbench

Sequential signed integer divider, the inverse companion of the team's sequential signed multiplier. It takes two two's-complement operands, converts them to magnitudes, and runs a restoring shift-subtract loop, one quotient bit per clock. It returns sign-magnitude quotient and remainder with sign, zero and divide-by-zero flags, and truncates toward zero. It sits beside the multiplier in the arithmetic datapath, driven by the same control sequencer through a start/busy/done handshake.

---
 rtl/signed_divider_if.sv | 38 +++
 rtl/signed_divider.sv | 197 +++++++++++++++++++
 tb/tb_signed_divider.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/signed_divider_if.sv
`default_nettype none
// ============================================================================
// Module   : signed_divider_if
// Purpose  : Start/busy/done handshake and operand/result bundle for the
//            sequential signed divider.
// Signals  : start, dividend, divisor          (master -> slave)
//            quotient, remainder, q_sign, r_sign,
//            zflag, dzflag, busy, done          (slave -> master)
// Modports : master - control sequencer / testbench side
//            slave  - divider side
// Revision : 1.0 - initial release
// ============================================================================
interface signed_divider_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-2:0] remainder;
  logic             q_sign;
  logic             r_sign;
  logic             zflag;
  logic             dzflag;
  logic             busy;
  logic             done;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, q_sign, r_sign, zflag, dzflag, busy, done
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, q_sign, r_sign, zflag, dzflag, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/signed_divider.sv
`default_nettype none
// ============================================================================
// Module   : signed_divider
// Purpose  : Sequential signed integer divider. Operands are converted to
//            magnitudes and divided by a restoring shift-subtract loop, one
//            quotient bit per clock. Results are sign-magnitude and truncate
//            toward zero.
// Ports    : clk   - system clock, rising edge
//            rst_n - asynchronous active-low reset
//            bus   - signed_divider_if.slave (start/operands in,
//                    quotient/remainder/flags/busy/done out)
// Revision : 1.0 - initial release
// ============================================================================
module signed_divider #(
  parameter int WIDTH = 8
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  signed_divider_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIV  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] C_ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH:0]   r_pr;        // partial remainder, one guard bit
  logic [WIDTH-1:0] r_qw;        // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] r_dvs;       // divisor magnitude
  logic             r_a_sign;
  logic             r_b_sign;

  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-2:0] r_rem;
  logic             r_q_sign;
  logic             r_r_sign;
  logic             r_zflag;
  logic             r_dzflag;

  logic             w_busy;
  logic             w_done;

  // --------------------------------------------------------------------------
  // Accept and operand conditioning
  // --------------------------------------------------------------------------
  logic             w_accept;
  logic             w_dvs_zero;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;

  assign w_accept   = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_dvs_zero = (bus.divisor == '0);

  // Unsigned reinterpretation makes |-2^(WIDTH-1)| come out as 2^(WIDTH-1).
  assign w_dvd_mag = bus.dividend[WIDTH-1] ? (~bus.dividend + C_ONE) : bus.dividend;
  assign w_dvs_mag = bus.divisor[WIDTH-1]  ? (~bus.divisor  + C_ONE) : bus.divisor;

  // --------------------------------------------------------------------------
  // One restoring step
  // --------------------------------------------------------------------------
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_dvs_ext;
  logic             w_ge;
  logic [WIDTH:0]   w_pr_next;
  logic [WIDTH-1:0] w_q_next;
  logic             w_last;

  assign w_shift   = {r_pr[WIDTH-1:0], r_qw[WIDTH-1]};
  assign w_dvs_ext = {1'b0, r_dvs};
  assign w_ge      = (w_shift >= w_dvs_ext);
  assign w_pr_next = w_ge ? (w_shift - w_dvs_ext) : w_shift;
  assign w_q_next  = {r_qw[WIDTH-2:0], w_ge};
  assign w_last    = (r_cnt == C_CNT_LAST);

  // The partial remainder stays below |divisor| <= 2^(WIDTH-1) between
  // steps, so its guard bit is never needed as a shift source.
  logic w_unused_bits;
  assign w_unused_bits = r_pr[WIDTH];

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          w_state_next = w_dvs_zero ? S_DONE : S_DIV;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_DIV: begin
        w_state_next = w_last ? S_DONE : S_DIV;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_DIV:   w_busy = 1'b1;
      S_DONE:  w_done = 1'b1;
      default: begin
        w_busy = 1'b0;
        w_done = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath and result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_pr     <= '0;
      r_qw     <= '0;
      r_dvs    <= '0;
      r_a_sign <= 1'b0;
      r_b_sign <= 1'b0;
      r_quot   <= '0;
      r_rem    <= '0;
      r_q_sign <= 1'b0;
      r_r_sign <= 1'b0;
      r_zflag  <= 1'b0;
      r_dzflag <= 1'b0;
    end else if (w_accept) begin
      r_dvs    <= w_dvs_mag;
      r_qw     <= w_dvd_mag;
      r_pr     <= '0;
      r_cnt    <= '0;
      r_a_sign <= bus.dividend[WIDTH-1];
      r_b_sign <= bus.divisor[WIDTH-1];
      r_dzflag <= w_dvs_zero;
      // Divide-by-zero completes on the accept edge itself.
      if (w_dvs_zero) begin
        r_quot   <= '0;
        r_rem    <= '0;
        r_q_sign <= 1'b0;
        r_r_sign <= 1'b0;
        r_zflag  <= 1'b1;
      end
    end else if (r_state == S_DIV) begin
      r_pr  <= w_pr_next;
      r_qw  <= w_q_next;
      r_cnt <= r_cnt + C_CNT_ONE;
      if (w_last) begin
        r_quot   <= w_q_next;
        r_rem    <= w_pr_next[WIDTH-2:0];
        r_q_sign <= (r_a_sign ^ r_b_sign) && (w_q_next != '0);
        r_r_sign <= r_a_sign && (w_pr_next != '0);
        r_zflag  <= (w_q_next == '0);
      end
    end
  end

  assign bus.quotient  = r_quot;
  assign bus.remainder = r_rem;
  assign bus.q_sign    = r_q_sign;
  assign bus.r_sign    = r_r_sign;
  assign bus.zflag     = r_zflag;
  assign bus.dzflag    = r_dzflag;
  assign bus.busy      = w_busy;
  assign bus.done      = w_done;

endmodule
`default_nettype wire

// File: tb/tb_signed_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_signed_divider
// Purpose  : Directed scoreboard testbench for signed_divider. Stimulus pushes
//            hand-computed expected results (including the cycle done must
//            appear in); a monitor pops and compares on every done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_signed_divider;

  localparam int WIDTH = 8;

  logic clk;
  logic rst_n;
  int   cyc;
  int   tests;
  int   failed;

  signed_divider_if #(.WIDTH(WIDTH)) bus ();

  signed_divider #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int q;
    int r;
    int qs;
    int rs;
    int z;
    int dz;
    int cyc;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  exp_t m_e;
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (sb.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
      end else begin
        m_e = sb.pop_front();
        chk("quotient",   int'(bus.quotient),  m_e.q);
        chk("remainder",  int'(bus.remainder), m_e.r);
        chk("q_sign",     int'(bus.q_sign),    m_e.qs);
        chk("r_sign",     int'(bus.r_sign),    m_e.rs);
        chk("zflag",      int'(bus.zflag),     m_e.z);
        chk("dzflag",     int'(bus.dzflag),    m_e.dz);
        chk("done_cycle", cyc,                 m_e.cyc);
        chk("busy_with_done", int'(bus.busy),  0);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers (called at a negedge with the DUT in IDLE or DONE)
  // --------------------------------------------------------------------------
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input int q, input int r, input int qs, input int rs,
                       input int z, input int dz, input int lat, input bit push);
    exp_t e;
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    if (push) begin
      e.q = q; e.r = r; e.qs = qs; e.rs = rs; e.z = z; e.dz = dz;
      e.cyc = cyc + lat;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = WIDTH'($urandom);
    bus.divisor  = WIDTH'($urandom);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      tests++;
      failed++;
      $display("FAIL timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_quotient"},  int'(bus.quotient),  0);
    chk({tag, "_remainder"}, int'(bus.remainder), 0);
    chk({tag, "_q_sign"},    int'(bus.q_sign),    0);
    chk({tag, "_r_sign"},    int'(bus.r_sign),    0);
    chk({tag, "_zflag"},     int'(bus.zflag),     0);
    chk({tag, "_dzflag"},    int'(bus.dzflag),    0);
    chk({tag, "_busy"},      int'(bus.busy),      0);
    chk({tag, "_done"},      int'(bus.done),      0);
  endtask

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  initial begin
    tests        = 0;
    failed       = 0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // 100 / 7
    issue(8'd100, 8'd7, 14, 2, 0, 0, 0, 0, 9, 1'b1);
    wait_idle();

    // -100 / 7 then 100 / -7 back-to-back, second accepted on the DONE edge
    issue(8'h9C, 8'd7, 14, 2, 1, 1, 0, 0, 9, 1'b1);
    repeat (8) @(negedge clk);
    chk("b2b_in_done", int'(bus.done), 1);
    issue(8'd100, 8'hF9, 14, 2, 1, 0, 0, 0, 9, 1'b1);
    wait_idle();

    // -128 / -1, then 3 / -7
    issue(8'h80, 8'hFF, 128, 0, 0, 0, 0, 0, 9, 1'b1);
    wait_idle();
    issue(8'd3, 8'hF9, 0, 3, 0, 0, 1, 0, 9, 1'b1);
    wait_idle();

    // 5 / 0: done on the next cycle, busy never asserted
    issue(8'd5, 8'd0, 0, 0, 0, 0, 1, 1, 1, 1'b1);
    chk("dz_busy", int'(bus.busy), 0);
    wait_idle();
    issue(8'd6, 8'd3, 2, 0, 0, 0, 0, 0, 9, 1'b1);
    wait_idle();

    // 127 / 2 with an ignored 9 / 3 start mid-division
    issue(8'd127, 8'd2, 63, 1, 0, 0, 0, 0, 9, 1'b1);
    repeat (2) @(negedge clk);
    chk("mid_busy", int'(bus.busy), 1);
    issue(8'd9, 8'd3, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    wait_idle();
    repeat (12) @(negedge clk);

    // Reset during DIV: aborts silently, then a cold 50 / 5
    issue(8'd100, 8'd7, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all_zero("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    issue(8'd50, 8'd5, 10, 0, 0, 0, 0, 0, 9, 1'b1);
    wait_idle();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
